// File: rtl/adder_op_seq.sv
// adder_op_seq: sequencing stage wrapped around the external ripple-carry adder.
//
// An operand pair is accepted over a valid/ready handshake and registered onto
// add_a/add_b. The block waits SETTLE cycles for the carry to ripple, samples
// add_f, and presents the registered result over a second valid/ready handshake.
// This block does no arithmetic of its own; the sum comes entirely from add_f.
//
// Parameters:
//   WIDTH   operand width; must match the adder instance
//   SETTLE  cycles allowed for carry ripple before sampling (legal 1..15)
//   CNT_W   width of the completed-transaction counter
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; op_a/op_b operands
//   add_a/add_b          registered operands driven to the adder
//   add_f                adder sum, bit WIDTH is carry-out
//   res_valid/res_ready  result handshake
//   res_sum/res_carry    registered sum and carry-out
//   res_zero             res_sum == 0 (carry ignored)
//   busy                 FSM not in IDLE
//   txn_count            completed result handshakes, wraps silently
//   res_ovf              signed-overflow flag, present only with ADD_OVF_FLAG_EN
//
// Build option: define ADD_OVF_FLAG_EN to add the res_ovf output.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for an operand pair
// ST_SETTLE | operands held on the adder, settle counter running down
// ST_DONE   | result registered, waiting for res_ready

module adder_op_seq #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_f,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_carry,
  output logic             res_zero,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
`ifdef ADD_OVF_FLAG_EN
  ,
  output logic             res_ovf
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // The counter is loaded with SETTLE-1 and sampling happens on the edge it
  // reads zero, so the operands sit on the adder for exactly SETTLE edges.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] settle_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      add_a      <= '0;
      add_b      <= '0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_zero   <= 1'b0;
      res_valid  <= 1'b0;
      txn_count  <= '0;
`ifdef ADD_OVF_FLAG_EN
      res_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            add_a      <= op_a;
            add_b      <= op_b;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            res_sum   <= add_f[WIDTH-1:0];
            res_carry <= add_f[WIDTH];
            res_zero  <= (add_f[WIDTH-1:0] == '0);
`ifdef ADD_OVF_FLAG_EN
            // Like-signed operands whose sum changes sign.
            res_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                         (add_f[WIDTH-1] != add_a[WIDTH-1]);
`endif
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          // in_valid is deliberately ignored here: a new pair can only be
          // taken from IDLE, one cycle after the result handshake.
          if (res_ready) begin
            res_valid <= 1'b0;
            txn_count <= txn_count + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Gated with rst_n so the upstream never sees ready while reset is held.
  assign in_ready = (state == ST_IDLE) & rst_n;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_adder_op_seq.sv
module tb_adder_op_seq;

  localparam int WIDTH  = 8;
  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   add_f;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_carry;
  logic             res_zero;
  logic             busy;
  logic [CNT_W-1:0] txn_count;
`ifdef ADD_OVF_FLAG_EN
  logic             res_ovf;
`endif

  adder_op_seq #(.WIDTH(WIDTH), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_f     (add_f),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_zero  (res_zero),
    .busy      (busy),
    .txn_count (txn_count)
`ifdef ADD_OVF_FLAG_EN
    ,
    .res_ovf   (res_ovf)
`endif
  );

  // Stand-in for the external combinational adder.
  assign add_f = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
    logic       zero;
    logic       ovf;
    int         t_acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  bit   rr_rand = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned and signed integer addition.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int t);
    exp_t m;
    int u;
    int s;
    u = int'(a) + int'(b);
    s = int'($signed(a)) + int'($signed(b));
    m.a     = a;
    m.b     = b;
    m.sum   = 8'(u % 256);
    m.carry = (u > 255);
    m.zero  = ((u % 256) == 0);
    m.ovf   = (s > 127) || (s < -128);
    m.t_acc = t;
    return m;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rr_rand) res_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: pops the scoreboard when a result appears, checks hold stability.
  initial begin
    exp_t cur;
    bit   have_cur = 0;
    bit   prev_valid = 0;
    bit   hs_prev = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 0;
        hs_prev    = 0;
        have_cur   = 0;
        continue;
      end
      chk("txn_count", 32'(txn_count), 32'(model_cnt % 256));
      chk("busy_vs_in_ready", 32'(busy), 32'(!in_ready));
      if (hs_prev) chk("valid_drop_after_handshake", 32'(res_valid), 0);
      if (res_valid) begin
        chk("in_ready_in_done", 32'(in_ready), 0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_res_valid", 32'(res_valid), 0);
            have_cur = 0;
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            chk("latency", 32'(cyc - cur.t_acc), 32'(SETTLE));
            chk("res_sum", 32'(res_sum), 32'(cur.sum));
            chk("res_carry", 32'(res_carry), 32'(cur.carry));
            chk("res_zero", 32'(res_zero), 32'(cur.zero));
`ifdef ADD_OVF_FLAG_EN
            chk("res_ovf", 32'(res_ovf), 32'(cur.ovf));
`endif
          end
        end else if (have_cur) begin
          chk("hold_res_sum", 32'(res_sum), 32'(cur.sum));
          chk("hold_res_carry", 32'(res_carry), 32'(cur.carry));
          chk("hold_add_a", 32'(add_a), 32'(cur.a));
          chk("hold_add_b", 32'(add_b), 32'(cur.b));
        end
        if (res_ready) model_cnt++;
      end else if (exp_q.size() > 0 && (cyc - exp_q[0].t_acc) >= SETTLE) begin
        chk("result_missing", 32'(res_valid), 1);
        void'(exp_q.pop_front());
      end
      hs_prev    = res_valid & res_ready;
      prev_valid = res_valid;
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    @(negedge clk);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (in_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      chk("accept_timeout", 32'(in_ready), 1);
      in_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, b, cyc + 1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
    @(negedge clk);
    chk("add_a_after_accept", 32'(add_a), 32'(a));
    chk("add_b_after_accept", 32'(add_b), 32'(b));
    chk("in_ready_after_accept", 32'(in_ready), 0);
  endtask

  task automatic wait_cnt(input int target);
    bit ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (model_cnt >= target && !busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("wait_done_timeout", 32'(model_cnt), 32'(target));
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_txn_count", 32'(txn_count), 0);
    chk("rst_add_a", 32'(add_a), 0);
    chk("rst_res_sum", 32'(res_sum), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_after_release", 32'(in_ready), 1);

    // Directed operand pairs.
    res_ready = 1'b1;
    send(8'h3C, 8'h42);
    wait_cnt(1);
    chk("txn_count_first", 32'(txn_count), 1);
    send(8'hFF, 8'h01);
    send(8'h7F, 8'h01);
    send(8'h80, 8'h80);
    send(8'h00, 8'h00);
    wait_cnt(5);

    // Backpressure with a new pair already waiting on in_valid.
    res_ready = 1'b0;
    send(8'h11, 8'h22);
    fork
      send(8'h33, 8'h44);
      begin
        bit seen = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (res_valid) begin
            seen = 1;
            break;
          end
        end
        if (!seen) chk("bp_valid_timeout", 32'(res_valid), 1);
        repeat (5) @(posedge clk);
        chk("bp_txn_count_held", 32'(txn_count), 5);
        #1 res_ready = 1'b1;
      end
    join
    wait_cnt(7);

    // Randomized operands with random downstream backpressure.
    rr_rand = 1;
    for (int i = 0; i < 40; i++) send(8'($urandom), 8'($urandom));
    rr_rand = 0;
    #1 res_ready = 1'b1;
    wait_cnt(47);

    // Reset while in SETTLE.
    send(8'h12, 8'h34);
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    model_cnt = 0;
    chk("arst_add_a", 32'(add_a), 0);
    chk("arst_add_b", 32'(add_b), 0);
    chk("arst_res_valid", 32'(res_valid), 0);
    chk("arst_txn_count", 32'(txn_count), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("in_ready_after_arst", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_valid_after_arst", 32'(res_valid), 0);
    end

    // Counter wrap over 256 transactions.
    for (int i = 0; i < 255; i++) send(8'($urandom), 8'($urandom));
    wait_cnt(255);
    chk("txn_count_255", 32'(txn_count), 255);
    send(8'($urandom), 8'($urandom));
    wait_cnt(256);
    chk("txn_count_wrap", 32'(txn_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
